frame_tx: RTL and testbench

- Transmit side of the terminator-delimited word stream.
- Collects payload words from an upstream valid/ready source into an internal block RAM.
- On `send`, replays the payload on a `we`/`dout` strobe interface, then appends the terminator word.
- Output connects directly to the `we`/`din` input of the frame-capture RAM, which stops capturing on the terminator.

---
 rtl/frame_pkg.sv | 26 ++
 rtl/frame_buf_ram.sv | 37 +++
 rtl/frame_tx.sv | 198 +++++++++++++++++++
 tb/tb_frame_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared constants and FSM encoding for the terminator-delimited word stream.
// FRAME_TX_LEN_HDR_EN adds the HDR state used by the optional length header.
package frame_pkg;

    localparam int          DATA_WIDTH_DEF = 16;
    localparam int          MEM_SIZE_DEF   = 256;
    localparam logic [15:0] TERM_WORD_DEF  = 16'hAABB;

    // Encoding is fixed so the value seen on a debug bus is stable with or
    // without the optional header.
    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_SEND = 3'd1,
        ST_TERM = 3'd2,
`ifdef FRAME_TX_LEN_HDR_EN
        ST_HDR  = 3'd4,
`endif
        ST_DONE = 3'd3
    } state_e;

    // Every state between the send request and the done pulse reports busy.
    function automatic logic is_busy_state(input state_e s);
        return (s != ST_LOAD) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port payload buffer: synchronous write, registered read.
// A read of the address being written in the same cycle returns the new word.
module frame_buf_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write-first forwarding lets a word accepted alongside send lead the frame.
    always_comb begin
        rd_data_d = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end

    // NOTE: storage and its read register carry no reset so they map onto a
    // block RAM; the controller never reads a location it has not written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_tx.sv
// Frame transmitter: buffers payload words, then replays them followed by the
// terminator word. FRAME_TX_LEN_HDR_EN prepends a word-count header.
module frame_tx
    import frame_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                    MEM_SIZE   = MEM_SIZE_DEF,
    parameter logic [DATA_WIDTH-1:0] TERM_WORD  = DATA_WIDTH'(TERM_WORD_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  send,
    output logic                  busy,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  done,
    output logic                  err
);

    localparam int             AW         = $clog2(MEM_SIZE);
    localparam int             CW         = AW + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(MEM_SIZE);

    state_e                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  from_ram_q, from_ram_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  store;
    logic                  ram_we;
    logic [AW-1:0]         ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  launch;
    logic [CW-1:0]         launch_cnt;

    assign accept = (state_q == ST_LOAD) && s_valid && s_ready_q;
    assign store  = accept && (s_data != TERM_WORD);

    // The RAM read is registered, so the address runs one word ahead of dout:
    // index 0 is fetched while send is sampled, rd_ptr_q onwards during SEND.
    assign ram_rd_addr = (state_q == ST_SEND) ? rd_ptr_q : '0;

    frame_buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_SIZE),
        .AW         (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (s_data),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        we_d       = 1'b0;
        from_ram_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ram_we     = 1'b0;
        launch     = 1'b0;
        launch_cnt = count_q;

        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (store) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (send) begin
                    rd_ptr_d = '0;
`ifdef FRAME_TX_LEN_HDR_EN
                    state_d = ST_HDR;
                    we_d    = 1'b1;
                    dout_d  = DATA_WIDTH'(count_d);
                    if (DATA_WIDTH'(count_d) == TERM_WORD) begin
                        err_d = 1'b1;
                    end
`else
                    launch     = 1'b1;
                    launch_cnt = count_d;
`endif
                end
            end
`ifdef FRAME_TX_LEN_HDR_EN
            ST_HDR: begin
                launch     = 1'b1;
                launch_cnt = count_q;
            end
`endif
            ST_SEND: begin
                // Truncated compare: a full buffer wraps rd_ptr to 0, which
                // matches the low bits of count == MEM_SIZE.
                if (rd_ptr_q == count_q[AW-1:0]) begin
                    state_d = ST_TERM;
                    we_d    = 1'b1;
                    dout_d  = TERM_WORD;
                end else begin
                    we_d       = 1'b1;
                    from_ram_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                end
            end
            ST_TERM: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d  = ST_LOAD;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Start of the replay: empty frames go straight to the terminator.
        if (launch) begin
            we_d = 1'b1;
            if (launch_cnt == '0) begin
                state_d = ST_TERM;
                dout_d  = TERM_WORD;
            end else begin
                state_d    = ST_SEND;
                from_ram_d = 1'b1;
                rd_ptr_d   = AW'(1);
            end
        end

        busy_d    = is_busy_state(state_d);
        s_ready_d = (state_d == ST_LOAD) && (count_d < FULL_COUNT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s_ready_q  <= 1'b1;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            dout_q     <= '0;
            from_ram_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
            dout_q     <= dout_d;
            from_ram_q <= from_ram_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Payload words come straight off the RAM output register.
    assign dout    = from_ram_q ? ram_rd_data : dout_q;
    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign we      = we_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: expected words are queued when a frame is
// sent and a negedge monitor compares every strobed word against the queue.
module tb_frame_tx;

    localparam int          DW   = 16;
    localparam int          MEM  = 256;
    localparam logic [15:0] TERM = 16'hAABB;
`ifdef FRAME_TX_LEN_HDR_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          send = 1'b0;
    logic          busy;
    logic          we;
    logic [DW-1:0] dout;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] sb_q[$];
    logic [15:0] frame_q[$];
    logic [15:0] exp_w;

    always #5 clk = ~clk;

    frame_tx #(
        .DATA_WIDTH (DW),
        .MEM_SIZE   (MEM),
        .TERM_WORD  (TERM)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .send    (send),
        .busy    (busy),
        .we      (we),
        .dout    (dout),
        .done    (done),
        .err     (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobed word must be the next expected one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_we: got dout %h with nothing expected", dout);
                end else begin
                    exp_w = sb_q.pop_front();
                    check("dout", 32'(dout), 32'(exp_w));
                end
            end
            if (done === 1'b1) begin
                check("done_after_term", 32'(sb_q.size()), 32'd0);
            end
        end
    end

    task automatic push_word(input logic [15:0] d);
        int w = 0;
        while (s_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (s_ready !== 1'b1) begin
            check("push_ready_timeout", 32'(s_ready), 32'd1);
        end
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
        if (d == TERM) begin
            check("err_pulse", 32'(err), 32'd1);
        end else begin
            frame_q.push_back(d);
            check("err_quiet", 32'(err), 32'd0);
        end
    endtask

    // Moves the bench's copy of the buffered frame into the scoreboard.
    task automatic load_expected(output int n);
        n = frame_q.size();
        if (HDR_WORDS != 0) sb_q.push_back(16'(n));
        foreach (frame_q[i]) sb_q.push_back(frame_q[i]);
        sb_q.push_back(TERM);
        frame_q.delete();
    endtask

    task automatic do_send(input string tag, input bit with_word, input logic [15:0] d);
        int n;
        int cycles = 0;
        int we_cnt = 0;
        if (with_word) begin
            s_valid = 1'b1;
            s_data  = d;
            frame_q.push_back(d);
        end
        load_expected(n);
        send = 1'b1;
        tick();
        send    = 1'b0;
        s_valid = 1'b0;
        check({tag, "_first_we"}, 32'(we), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && cycles < 400) begin
            if (we === 1'b1) we_cnt++;
            tick();
            cycles++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_we_cycles"}, 32'(we_cnt), 32'(n + 1 + HDR_WORDS));
        check({tag, "_we_gapless"}, 32'(we_cnt), 32'(cycles));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_we_at_done"}, 32'(we), 32'd0);
        check({tag, "_dout_at_done"}, 32'(dout), 32'(TERM));
        tick();
        check({tag, "_ready_after"}, 32'(s_ready), 32'd1);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n_dummy;

        #12;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic three-word frame.
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        do_send("basic", 1'b0, 16'h0);

        // Empty buffer: terminator only.
        do_send("empty", 1'b0, 16'h0);

        // Terminator value in the payload is consumed and dropped.
        push_word(16'h5555);
        push_word(TERM);
        push_word(16'h6666);
        do_send("term_reject", 1'b0, 16'h0);

        // Full buffer, a refused 257th word, then a frame after the wrap.
        for (int i = 0; i < MEM; i++) begin
            push_word({8'h5A, 8'(i)});
        end
        check("full_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        tick();
        s_valid = 1'b0;
        check("full_still_blocked", 32'(s_ready), 32'd0);
        do_send("full", 1'b0, 16'h0);
        push_word(16'h0101);
        push_word(16'h0202);
        push_word(16'h0303);
        do_send("wrap", 1'b0, 16'h0);

        // Word accepted in the send cycle closes the frame.
        push_word(16'h7777);
        do_send("same_cycle", 1'b1, 16'h4444);
        do_send("same_cycle_empty", 1'b1, 16'h4545);

        // Reset in the middle of SEND aborts the frame.
        push_word(16'h8001);
        push_word(16'h8002);
        push_word(16'h8003);
        push_word(16'h8004);
        load_expected(n_dummy);
        send = 1'b1;
        tick();
        send = 1'b0;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_we", 32'(we), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        sb_q.delete();
        frame_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("postreset_ready", 32'(s_ready), 32'd1);
        push_word(16'h9001);
        push_word(16'h9002);
        push_word(16'h9003);
        do_send("after_reset", 1'b0, 16'h0);

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
